// File: rtl/audio_clock_gen.sv
// rtl/audio_clock_gen.sv - codec master/bit/word clock generator with frame-aligned start/stop
// XCK = iCLK/2; BCK and LRCK derived from a divide-by-D counter, LRCK moving only on BCK falls.
module audio_clock_gen #(
  parameter int REF_CLK     = 18432000,
  parameter int SAMPLE_RATE = 48000,
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNEL_NUM = 2
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iEN,
  output logic        AUD_XCK,
  output logic        AUD_BCK,
  output logic        AUD_LRCK,
  output logic        oBCK_FALL,
  output logic        oSAMPLE_DONE,
  output logic        oSAMPLE_CH,
  output logic [15:0] oFRAME_CNT,
  output logic        oBUSY
);

  localparam int BCK_EDGE_RATE = SAMPLE_RATE * DATA_WIDTH * CHANNEL_NUM * 2;
  localparam int D             = REF_CLK / BCK_EDGE_RATE;
  localparam int DIV_W         = (D > 1) ? $clog2(D) : 1;
  localparam int BIT_W         = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(D - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  generate
    if (CHANNEL_NUM != 2) begin : g_bad_channels
      $error("audio_clock_gen: CHANNEL_NUM must be 2");
    end
    if (D == 0 || (REF_CLK % BCK_EDGE_RATE) != 0) begin : g_bad_divider
      $error("audio_clock_gen: REF_CLK is not an exact multiple of the BCK edge rate");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               xck_q, xck_d;
  logic               bck_q, bck_d;
  logic               lrck_q, lrck_d;
  logic               bck_fall_q, bck_fall_d;
  logic               sample_done_q, sample_done_d;
  logic               sample_ch_q, sample_ch_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bit_d         = bit_q;
    xck_d         = ~xck_q;
    bck_d         = bck_q;
    lrck_d        = lrck_q;
    bck_fall_d    = 1'b0;
    sample_done_d = 1'b0;
    sample_ch_d   = sample_ch_q;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        bck_d  = 1'b0;
        lrck_d = 1'b0;
        div_d  = '0;
        bit_d  = '0;
        if (iEN) begin
          state_d = ST_RUN;
          lrck_d  = 1'b1;
        end
      end

      ST_RUN, ST_STOP: begin
        if (state_q == ST_RUN && !iEN) begin
          state_d = ST_STOP;
        end else if (state_q == ST_STOP && iEN) begin
          state_d = ST_RUN;
        end

        if (div_q == DIV_LAST) begin
          div_d = '0;
          bck_d = ~bck_q;
          if (bck_q) begin
            bck_fall_d = 1'b1;
            bit_d      = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) begin
              bit_d         = '0;
              lrck_d        = ~lrck_q;
              sample_done_d = 1'b1;
              sample_ch_d   = lrck_q;
              // Right half just ended: this is the frame boundary where a pending stop lands.
              if (!lrck_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (state_q == ST_STOP && !iEN) begin
                  state_d = ST_IDLE;
                  lrck_d  = 1'b0;
                end
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        bck_d   = 1'b0;
        lrck_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      bit_q         <= '0;
      xck_q         <= 1'b0;
      bck_q         <= 1'b0;
      lrck_q        <= 1'b0;
      bck_fall_q    <= 1'b0;
      sample_done_q <= 1'b0;
      sample_ch_q   <= 1'b0;
      frame_cnt_q   <= 16'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      xck_q         <= xck_d;
      bck_q         <= bck_d;
      lrck_q        <= lrck_d;
      bck_fall_q    <= bck_fall_d;
      sample_done_q <= sample_done_d;
      sample_ch_q   <= sample_ch_d;
      frame_cnt_q   <= frame_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign AUD_XCK      = xck_q;
  assign AUD_BCK      = bck_q;
  assign AUD_LRCK     = lrck_q;
  assign oBCK_FALL    = bck_fall_q;
  assign oSAMPLE_DONE = sample_done_q;
  assign oSAMPLE_CH   = sample_ch_q;
  assign oFRAME_CNT   = frame_cnt_q;
  assign oBUSY        = busy_q;

endmodule
